// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// Each granted access runs a fixed IDLE -> SETUP -> ACCESS -> ACK sequence.
module ram_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int ADDRESS_SIZE = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0,
    input  logic                    req1,
    input  logic                    we0,
    input  logic                    we1,
    input  logic [ADDRESS_SIZE-1:0] addr0,
    input  logic [ADDRESS_SIZE-1:0] addr1,
    input  logic [WORD_SIZE-1:0]    wdata0,
    input  logic [WORD_SIZE-1:0]    wdata1,
    output logic                    ack0,
    output logic                    ack1,
    output logic [WORD_SIZE-1:0]    rdata0,
    output logic [WORD_SIZE-1:0]    rdata1,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0]    mem_wdata,
    output logic                    mem_write,
    input  logic [WORD_SIZE-1:0]    mem_rdata,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        ACK
    } state_t;

    state_t                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    last_q, last_d;
    logic                    we_q, we_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
    logic [WORD_SIZE-1:0]    rdata0_q, rdata0_d;
    logic [WORD_SIZE-1:0]    rdata1_q, rdata1_d;
    logic                    winner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        // Under contention the port not granted last wins; a lone request always wins.
        winner   = (req0 && req1) ? ~last_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d = winner;
                    last_d  = winner;
                    we_d    = winner ? we1 : we0;
                    addr_d  = winner ? addr1 : addr0;
                    wdata_d = winner ? wdata1 : wdata0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (!we_q) begin
                    if (grant_q) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata0_d = mem_rdata;
                    end
                end
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from registered state so reset clears them immediately.
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_write   = (state_q == ACCESS) && we_q;
    assign ack0        = (state_q == ACK) && !grant_q;
    assign ack1        = (state_q == ACK) && grant_q;
    assign busy        = (state_q != IDLE);
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus queues expected acks and RAM writes,
// monitors pop and compare whenever the DUT pulses an ack or a write strobe.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [14:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic [14:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_write;
    logic [15:0] mem_rdata;
    logic        busy;

    typedef struct {
        logic        port;
        logic [15:0] r0;
        logic [15:0] r1;
    } ackExp_t;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
    } writeExp_t;

    ackExp_t     ackQ[$];
    writeExp_t   writeQ[$];
    logic [15:0] ram [0:32767];
    int          compared = 0;
    int          mismatched = 0;
    int          cycle = 0;
    int          ackCount = 0;
    int          lastAckCycle = 0;
    int          prevAckCycle = 0;
    logic [15:0] expR0 = '0;
    logic [15:0] expR1 = '0;

    ram_arbiter #(.WORD_SIZE(16), .ADDRESS_SIZE(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_address];

    always @(posedge clk) begin
        if (mem_write) ram[mem_address] <= mem_wdata;
        cycle <= cycle + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Ack monitor: every ack pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ack0 && ack1) checkOutput("ackOverlap", {ack0, ack1}, 2'b00);
        if (ack0 || ack1) begin
            if (ackQ.size() == 0) begin
                checkOutput("unexpectedAck", {ack0, ack1}, 2'b00);
            end else begin
                ackExp_t e;
                e = ackQ.pop_front();
                checkOutput("ackPort", {31'd0, ack1}, {31'd0, e.port});
                checkOutput("rdata0", rdata0, e.r0);
                checkOutput("rdata1", rdata1, e.r1);
            end
            prevAckCycle <= lastAckCycle;
            lastAckCycle <= cycle;
            ackCount     <= ackCount + 1;
        end
    end

    always @(negedge clk) begin
        if (mem_write) begin
            if (writeQ.size() == 0) begin
                checkOutput("unexpectedWrite", {31'd0, mem_write}, 32'd0);
            end else begin
                writeExp_t w;
                w = writeQ.pop_front();
                checkOutput("writeAddr", mem_address, w.addr);
                checkOutput("writeData", mem_wdata, w.data);
            end
        end
    end

    task automatic waitAck(input int target);
        int n = 0;
        while (ackCount < target && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (ackCount < target) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL ackTimeout: got %0d acks expected %0d", ackCount, target);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expR0 = '0;
        expR1 = '0;
    endtask

    // One isolated transaction; expData is the hand-computed read result.
    task automatic applyStimulus(input logic port, input logic we, input logic [14:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] expData);
        ackExp_t e;
        int startCycle;
        int target;
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end
        if (we) writeQ.push_back('{addr: addr, data: wdata});
        else if (port) expR1 = expData;
        else expR0 = expData;
        e = '{port: port, r0: expR0, r1: expR1};
        ackQ.push_back(e);
        target = ackCount + 1;
        @(posedge clk);
        #1;
        startCycle = cycle;
        req0 = 1'b0;
        req1 = 1'b0;
        checkOutput("busyAfterGrant", {31'd0, busy}, 32'd1);
        waitAck(target);
        checkOutput("ackLatency", lastAckCycle - startCycle, 32'd2);
        @(posedge clk);
        #1;
        checkOutput("busyBackIdle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = '0;
        we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0;
        wdata0 = '0; wdata1 = '0;
        doReset();

        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetWrite", {31'd0, mem_write}, 32'd0);
        checkOutput("resetAcks", {ack0, ack1}, 2'b00);
        checkOutput("resetAddr", mem_address, 15'h0000);
        checkOutput("resetRdata", {rdata0, rdata1}, 32'd0);

        applyStimulus(1'b0, 1'b1, 15'h0010, 16'hBEEF, 16'h0000);
        applyStimulus(1'b1, 1'b0, 15'h0010, 16'h0000, 16'hBEEF);
        checkOutput("idleHoldsAddr", mem_address, 15'h0010);
        applyStimulus(1'b0, 1'b1, 15'h7FFF, 16'h1234, 16'h0000);
        applyStimulus(1'b0, 1'b0, 15'h7FFF, 16'h0000, 16'h1234);
        applyStimulus(1'b0, 1'b0, 15'h0000, 16'h0000, 16'h0000);
        applyStimulus(1'b0, 1'b1, 15'h0000, 16'hAAAA, 16'h0000);
        applyStimulus(1'b1, 1'b0, 15'h7FFF, 16'h0000, 16'h1234);
        applyStimulus(1'b1, 1'b0, 15'h0000, 16'h0000, 16'hAAAA);

        // Inputs changing after the grant must not reach the RAM.
        req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0100; wdata0 = 16'h0F0F;
        writeQ.push_back('{addr: 15'h0100, data: 16'h0F0F});
        ackQ.push_back('{port: 1'b0, r0: expR0, r1: expR1});
        @(posedge clk);
        #1;
        req0 = 1'b0; addr0 = 15'h0200; wdata0 = 16'hFFFF;
        checkOutput("setupAddr", mem_address, 15'h0100);
        checkOutput("setupNoWrite", {31'd0, mem_write}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("accessAddr", mem_address, 15'h0100);
        checkOutput("accessWrite", {31'd0, mem_write}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("ackAddr", mem_address, 15'h0100);
        checkOutput("ackNoWrite", {31'd0, mem_write}, 32'd0);
        checkOutput("ack0Pulse", {ack0, ack1}, 2'b10);
        @(posedge clk);
        #1;

        // Continuous contention right after reset alternates 0,1,0,1.
        doReset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 15'h7FFF;
        ackQ.push_back('{port: 1'b0, r0: 16'hBEEF, r1: 16'h0000});
        ackQ.push_back('{port: 1'b1, r0: 16'hBEEF, r1: 16'h1234});
        ackQ.push_back('{port: 1'b0, r0: 16'hBEEF, r1: 16'h1234});
        ackQ.push_back('{port: 1'b1, r0: 16'hBEEF, r1: 16'h1234});
        begin
            int base;
            base = ackCount;
            waitAck(base + 1);
            for (int k = 2; k <= 4; k++) begin
                waitAck(base + k);
                checkOutput("ackSpacing", lastAckCycle - prevAckCycle, 32'd4);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        #1;

        // Reset during ACCESS of a write aborts the strobe and the ack.
        req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0020; wdata0 = 16'h9999;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abortStrobeHigh", {31'd0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abortStrobeDrop", {31'd0, mem_write}, 32'd0);
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortAck", {ack0, ack1}, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("abortNoAckLater", {ack0, ack1}, 2'b00);
        expR0 = '0;
        expR1 = '0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0020;
        req1 = 1'b1; we1 = 1'b0; addr1 = 15'h0010;
        ackQ.push_back('{port: 1'b0, r0: 16'h0000, r1: 16'h0000});
        ackQ.push_back('{port: 1'b1, r0: 16'h0000, r1: 16'hBEEF});
        rst_n = 1'b1;
        begin
            int base;
            base = ackCount;
            waitAck(base + 2);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        checkOutput("ackQueueDrained", ackQ.size(), 32'd0);
        checkOutput("writeQueueDrained", writeQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
